xor_frame_parity: RTL and testbench

- Streaming XOR parity engine that folds a frame of WIDTH-bit words into one column-parity word, bit by bit.
- Two modes, selected per frame:
  - generate: emits the parity word for the frame.
  - check: treats the last word as the received parity and flags a mismatch.
- Valid/ready on both input and output; one frame in flight at a time.
- Sits between a word source and a consumer in the datapath as the sequential, multi-word successor to the single XOR gate.

---
 rtl/xor_frame_parity.sv | 104 ++++++++++
 tb/tb_xor_frame_parity.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/xor_frame_parity.sv
// Streaming column-parity engine: folds a frame of words into one XOR word.
// Generate mode emits parity; check mode flags a nonzero residual or overflow.
module xor_frame_parity #(
  parameter int WIDTH   = 8,
  parameter int MAX_LEN = 16,
  parameter bit ODD     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_last,
  input  logic                         check_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_parity,
  output logic                         out_bitpar,
  output logic                         out_err,
  output logic [$clog2(MAX_LEN+1)-1:0] out_len,
  output logic                         out_overflow
);

  localparam int CW = $clog2(MAX_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             mode;

  logic             accept;
  logic             first;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic             mode_nxt;
  logic             hit_max;
  logic             close;
  logic             ovf_nxt;
  logic [WIDTH-1:0] par_nxt;

  assign in_ready  = (state == S_IDLE) | (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid & in_ready;
  assign first     = (state == S_IDLE);

  // The first word seeds the fold; later words XOR into it.
  always_comb begin
    acc_nxt  = acc ^ in_data;
    cnt_nxt  = cnt + CW'(1);
    mode_nxt = mode;
    if (first) begin
      acc_nxt  = in_data;
      cnt_nxt  = CW'(1);
      mode_nxt = check_en;
    end
    hit_max = (cnt_nxt == CW'(MAX_LEN));
    close   = in_last | hit_max;
    ovf_nxt = hit_max & ~in_last;
    par_nxt = acc_nxt ^ {WIDTH{ODD}};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      acc          <= '0;
      cnt          <= '0;
      mode         <= 1'b0;
      out_parity   <= '0;
      out_bitpar   <= 1'b0;
      out_err      <= 1'b0;
      out_len      <= '0;
      out_overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ACCUM: begin
          if (accept) begin
            acc  <= acc_nxt;
            cnt  <= cnt_nxt;
            mode <= mode_nxt;
            if (close) begin
              state        <= S_DONE;
              out_parity   <= par_nxt;
              out_bitpar   <= ^par_nxt;
              out_len      <= cnt_nxt;
              out_overflow <= ovf_nxt;
              out_err      <= mode_nxt & ((|par_nxt) | ovf_nxt);
            end else begin
              state <= S_ACCUM;
            end
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_frame_parity.sv
// Directed bench for xor_frame_parity: vector table plus hand sequences
// for backpressure, overflow and mid-frame reset.
module tb_xor_frame_parity;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       check_en;
  logic       out_ready;

  logic       rdy0, ov0, bp0, err0, ovf0;
  logic [7:0] par0;
  logic [2:0] len0;
  logic       rdy1, ov1, bp1, err1, ovf1;
  logic [7:0] par1;
  logic [2:0] len1;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  xor_frame_parity #(.WIDTH(8), .MAX_LEN(4), .ODD(1'b0)) u0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .check_en(check_en),
    .out_valid(ov0), .out_ready(out_ready),
    .out_parity(par0), .out_bitpar(bp0), .out_err(err0),
    .out_len(len0), .out_overflow(ovf0)
  );

  xor_frame_parity #(.WIDTH(8), .MAX_LEN(4), .ODD(1'b1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .check_en(check_en),
    .out_valid(ov1), .out_ready(out_ready),
    .out_parity(par1), .out_bitpar(bp1), .out_err(err1),
    .out_len(len1), .out_overflow(ovf1)
  );

  typedef struct {
    int             n;
    logic [3:0][7:0] w;
    logic           ce;
    logic           lst;
    logic [7:0]     par;
    logic           bp;
    logic           err;
    logic [2:0]     len;
    logic           ovf;
    logic [7:0]     par_odd;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the final accept.
  task automatic send(input int n, input logic [3:0][7:0] w,
                      input logic ce, input logic lst);
    int budget;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      in_last  = lst && (i == n - 1);
      check_en = ce;
      budget   = 0;
      while (!rdy0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 20) begin
        nbad++;
        $display("FAIL send_timeout: got in_ready=0 want 1");
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("pop_valid", ov0, 0);
    chk("pop_ready", rdy0, 1);
  endtask

  initial begin
    tbl[0] = '{3, {8'h00, 8'h0F, 8'h3C, 8'hA5}, 1'b0, 1'b1,
               8'h96, 1'b0, 1'b0, 3'd3, 1'b0, 8'h69};
    tbl[1] = '{3, {8'h00, 8'h26, 8'h34, 8'h12}, 1'b1, 1'b1,
               8'h00, 1'b0, 1'b0, 3'd3, 1'b0, 8'hFF};
    tbl[2] = '{3, {8'h00, 8'h27, 8'h34, 8'h12}, 1'b1, 1'b1,
               8'h01, 1'b1, 1'b1, 3'd3, 1'b0, 8'hFE};
    tbl[3] = '{4, {8'h08, 8'h04, 8'h02, 8'h01}, 1'b1, 1'b0,
               8'h0F, 1'b0, 1'b1, 3'd4, 1'b1, 8'hF0};
    tbl[4] = '{1, {8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1,
               8'h00, 1'b0, 1'b0, 3'd1, 1'b0, 8'hFF};
    tbl[5] = '{4, {8'h88, 8'h44, 8'h22, 8'h11}, 1'b0, 1'b1,
               8'hFF, 1'b0, 1'b0, 3'd4, 1'b0, 8'h00};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    check_en  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", ov0, 0);
    chk("rst_parity", par0, 8'h00);
    chk("rst_err", err0, 0);
    chk("rst_len", len0, 0);
    chk("rst_ready", rdy0, 1);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      send(tbl[v].n, tbl[v].w, tbl[v].ce, tbl[v].lst);
      chk($sformatf("v%0d_valid", v), ov0, 1);
      chk($sformatf("v%0d_ready", v), rdy0, 0);
      chk($sformatf("v%0d_parity", v), par0, tbl[v].par);
      chk($sformatf("v%0d_bitpar", v), bp0, tbl[v].bp);
      chk($sformatf("v%0d_err", v), err0, tbl[v].err);
      chk($sformatf("v%0d_len", v), len0, tbl[v].len);
      chk($sformatf("v%0d_ovf", v), ovf0, tbl[v].ovf);
      chk($sformatf("v%0d_par_odd", v), par1, tbl[v].par_odd);
      pop();
    end

    // Backpressure: result held, pending word not taken until release.
    send(3, {8'h00, 8'h0F, 8'h3C, 8'hA5}, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", ov0, 1);
      chk("bp_ready", rdy0, 0);
      chk("bp_parity", par0, 8'h96);
      chk("bp_len", len0, 3);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_rel_valid", ov0, 0);
    chk("bp_rel_ready", rdy0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("bp_new_valid", ov0, 1);
    chk("bp_new_parity", par0, 8'hFF);
    chk("bp_new_len", len0, 1);
    pop();

    // Reset in the middle of a frame leaves no residue.
    send(2, {8'h00, 8'h00, 8'hBB, 8'hAA}, 1'b1, 1'b0);
    chk("mid_accum_ready", rdy0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", ov0, 0);
    chk("mid_rst_parity", par0, 8'h00);
    chk("mid_rst_len", len0, 0);
    chk("mid_rst_ready", rdy0, 1);
    send(1, {8'h00, 8'h00, 8'h00, 8'h5A}, 1'b0, 1'b1);
    chk("post_rst_parity", par0, 8'h5A);
    chk("post_rst_par_odd", par1, 8'hA5);
    chk("post_rst_len", len0, 1);
    chk("post_rst_err", err0, 0);
    pop();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
